// File: rtl/count_capture.sv
// count_capture: extends an upstream counter value with an overflow epoch and
// snapshots coherent {epoch, count} pairs into a small FIFO that drains over a
// valid/ready stream. Captures that find the FIFO full are dropped and counted
// instead of back-pressuring the counter.
module count_capture #(
    parameter int WIDTH       = 8,
    parameter int EPOCH_WIDTH = 8,
    parameter int DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           count_in,
    input  logic                       overflow_in,
    input  logic                       enable_in,
    input  logic                       capture_in,
    input  logic                       clear_in,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_count,
    output logic [EPOCH_WIDTH-1:0]     m_epoch,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       dropped,
    output logic [7:0]                 drop_cnt
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FILL_W  = $clog2(DEPTH + 1);
    localparam int ENTRY_W = EPOCH_WIDTH + WIDTH;

    // State
    logic                   r_en_q;
    logic [EPOCH_WIDTH-1:0] r_epoch;
    logic [ENTRY_W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [FILL_W-1:0]      r_fill;
    logic                   r_dropped;
    logic [7:0]             r_drop_cnt;

    // Combinational control
    logic                   w_ovf_evt;
    logic [EPOCH_WIDTH-1:0] w_epoch_eff;
    logic                   w_full;
    logic                   w_valid;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic [ENTRY_W-1:0]     w_head;

    // The upstream overflow level persists while the counter is disabled, so
    // only the first cycle after an enabled cycle counts as a real wrap.
    assign w_ovf_evt   = overflow_in && r_en_q;
    // Fold a same-cycle wrap into the captured epoch so a count of 0 that has
    // just wrapped is tagged with the new epoch, not the old one.
    assign w_epoch_eff = r_epoch + EPOCH_WIDTH'(w_ovf_evt);

    assign w_full  = (r_fill == FILL_W'(DEPTH));
    assign w_valid = (r_fill != '0);
    assign w_pop   = w_valid && m_ready && !clear_in;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = capture_in && !clear_in && (!w_full || w_pop);
    assign w_drop  = capture_in && !clear_in && !w_push;

    // Registered enable, used to qualify the overflow level as an event.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_q <= 1'b0;
        end else begin
            r_en_q <= enable_in;
        end
    end

    // Overflow epoch: counts qualified wraps, wraps silently, zeroed by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_epoch <= '0;
        end else if (clear_in) begin
            r_epoch <= '0;
        end else if (w_ovf_evt) begin
            r_epoch <= r_epoch + EPOCH_WIDTH'(1);
        end
    end

    // FIFO storage write port.
    // NOTE: the entry array is deliberately left unreset; outputs are gated by
    // m_valid, so stale contents are never observable and reset stays cheap.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_epoch_eff, count_in};
        end
    end

    // FIFO pointers and occupancy; clear empties the FIFO outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else if (clear_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + FILL_W'(1);
                2'b01:   r_fill <= r_fill - FILL_W'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Drop status: sticky flag plus a saturating count of lost captures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dropped  <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clear_in) begin
            r_dropped  <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_dropped <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // Head entry comes straight from storage; it only changes on a push into
    // an empty FIFO or on a pop, so it is stable while stalled.
    assign w_head  = r_mem[r_rd_ptr];
    assign m_valid = w_valid;
    assign m_count = w_valid ? w_head[WIDTH-1:0] : '0;
    assign m_epoch = w_valid ? w_head[ENTRY_W-1:WIDTH] : '0;

    assign fill     = r_fill;
    assign dropped  = r_dropped;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_count_capture.sv
// Directed bench for count_capture: inputs change on the falling edge, outputs
// are checked on the falling edge, expected values are hand-computed.
module tb_count_capture;

    localparam int WIDTH       = 8;
    localparam int EPOCH_WIDTH = 8;
    localparam int DEPTH       = 4;

    logic                       clk;
    logic                       rst_n;
    logic [WIDTH-1:0]           count_in;
    logic                       overflow_in;
    logic                       enable_in;
    logic                       capture_in;
    logic                       clear_in;
    logic                       m_valid;
    logic                       m_ready;
    logic [WIDTH-1:0]           m_count;
    logic [EPOCH_WIDTH-1:0]     m_epoch;
    logic [$clog2(DEPTH+1)-1:0] fill;
    logic                       dropped;
    logic [7:0]                 drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    count_capture #(
        .WIDTH      (WIDTH),
        .EPOCH_WIDTH(EPOCH_WIDTH),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_in   (count_in),
        .overflow_in(overflow_in),
        .enable_in  (enable_in),
        .capture_in (capture_in),
        .clear_in   (clear_in),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_count    (m_count),
        .m_epoch    (m_epoch),
        .fill       (fill),
        .dropped    (dropped),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then back to the falling edge for checks and drive.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_head(input string tag, input int cnt, input int ep);
        check({tag, "_valid"}, 32'(m_valid), 32'd1);
        check({tag, "_count"}, 32'(m_count), 32'(cnt));
        check({tag, "_epoch"}, 32'(m_epoch), 32'(ep));
    endtask

    task automatic capture(input int cnt);
        count_in   = WIDTH'(cnt);
        capture_in = 1'b1;
        tick();
        capture_in = 1'b0;
    endtask

    task automatic pop();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_a [3];
        exp_a = '{5, 9, 12};

        rst_n = 1'b0; count_in = '0; overflow_in = 1'b0; enable_in = 1'b0;
        capture_in = 1'b0; clear_in = 1'b0; m_ready = 1'b0;
        tick();
        // Reset state
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_count", 32'(m_count), 32'd0);
        check("rst_epoch", 32'(m_epoch), 32'd0);
        check("rst_dropped", 32'(dropped), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Three captures held, then drained in order
        capture(5);
        check_head("first_cap", 5, 0);
        capture(9);
        capture(12);
        check("fill3", 32'(fill), 32'd3);
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_head($sformatf("drain%0d", i), exp_a[i], 0);
            tick();
        end
        m_ready = 1'b0;
        check("drain_fill", 32'(fill), 32'd0);
        check("drain_valid", 32'(m_valid), 32'd0);

        // Overflow level without enable is not an event
        overflow_in = 1'b1;
        tick();
        tick();
        capture(200);
        enable_in = 1'b1; overflow_in = 1'b0;
        tick();
        enable_in = 1'b0; overflow_in = 1'b1;
        capture(0);
        overflow_in = 1'b0;
        check_head("unqual_ovf", 200, 0);
        pop();
        check_head("qual_ovf", 0, 1);
        pop();
        check("ovf_fill", 32'(fill), 32'd0);

        // Clear, then overfill: 6 captures into 4 entries
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        for (int i = 0; i < 6; i++) capture(10 + i);
        check("full_fill", 32'(fill), 32'd4);
        check("full_dropped", 32'(dropped), 32'd1);
        check("full_drop_cnt", 32'(drop_cnt), 32'd2);
        check_head("full_head", 10, 0);

        // Full FIFO: capture and pop in the same cycle
        m_ready = 1'b1;
        capture(16);
        m_ready = 1'b0;
        check("pushpop_fill", 32'(fill), 32'd4);
        check("pushpop_drop_cnt", 32'(drop_cnt), 32'd2);
        check_head("pushpop_head", 11, 0);

        // Seven qualified overflow events -> epoch 7
        enable_in = 1'b1;
        tick();
        overflow_in = 1'b1;
        repeat (7) tick();
        overflow_in = 1'b0; enable_in = 1'b0;
        tick();
        pop();
        pop();
        check_head("pop3_head", 13, 0);
        pop();
        check_head("pop4_head", 16, 0);
        capture(77);
        check("pre_clr_fill", 32'(fill), 32'd2);
        pop();
        check_head("epoch7", 77, 7);
        capture(78);
        check("pre_clr_fill2", 32'(fill), 32'd2);
        check("pre_clr_dropped", 32'(dropped), 32'd1);

        // Clear beats a same-cycle capture
        clear_in = 1'b1;
        capture(88);
        clear_in = 1'b0;
        check("clr_fill", 32'(fill), 32'd0);
        check("clr_valid", 32'(m_valid), 32'd0);
        check("clr_dropped", 32'(dropped), 32'd0);
        check("clr_drop_cnt", 32'(drop_cnt), 32'd0);
        capture(33);
        check_head("post_clr", 33, 0);
        pop();

        // 255 events, capture (255,1); 256th event with capture -> (0,0)
        enable_in = 1'b1;
        tick();
        overflow_in = 1'b1;
        repeat (255) tick();
        overflow_in = 1'b0;
        capture(1);
        overflow_in = 1'b1;
        capture(0);
        overflow_in = 1'b0;
        capture(2);
        enable_in = 1'b0;
        check_head("ep255", 1, 255);
        pop();
        check_head("ep_wrap", 0, 0);
        pop();
        check_head("ep_after_wrap", 2, 0);
        capture(3);
        capture(4);
        capture(5);
        capture(6);
        check("pre_rst_fill", 32'(fill), 32'd4);
        check("pre_rst_drop_cnt", 32'(drop_cnt), 32'd1);

        // Asynchronous reset mid-stream: outputs clear before the next edge
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(m_valid), 32'd0);
        check("arst_fill", 32'(fill), 32'd0);
        check("arst_count", 32'(m_count), 32'd0);
        check("arst_epoch", 32'(m_epoch), 32'd0);
        check("arst_dropped", 32'(dropped), 32'd0);
        check("arst_drop_cnt", 32'(drop_cnt), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/count_capture.md
# count_capture

Timestamp capture stage that sits directly downstream of `counter`. It consumes the counter's `count`/`overflow` outputs and extends the count with an overflow epoch. On a capture strobe it snapshots the coherent `{epoch, count}` pair into a small FIFO. Captures drain to a consumer over a valid/ready stream. Overflowing captures are dropped and flagged rather than stalling the counter.

## Interface

Parameters:
- `WIDTH`, 8, width of `count_in` and `m_count`; matches the upstream counter's `WIDTH`.
- `EPOCH_WIDTH`, 8, width of the overflow epoch register and `m_epoch`.
- `DEPTH`, 4, FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; assertion is asynchronous, release is synchronous to `clk` (provided by the system).
- `count_in`  in  WIDTH  `count` from the upstream counter.
- `overflow_in`  in  1  `overflow` from the upstream counter.
- `enable_in`  in  1  the same `enable` that drives the upstream counter.
- `capture_in`  in  1  capture strobe; each high cycle is one capture request.
- `clear_in`  in  1  synchronous clear of epoch, FIFO and drop status.
- `m_valid`  out  1  head entry valid.
- `m_ready`  in  1  consumer accepts the head entry.
- `m_count`  out  WIDTH  head entry count.
- `m_epoch`  out  EPOCH_WIDTH  head entry epoch.
- `fill`  out  $clog2(DEPTH+1)  number of occupied entries.
- `dropped`  out  1  sticky: at least one capture was lost.
- `drop_cnt`  out  8  number of lost captures; saturates at 255.

## Operation

- **Overflow qualification.**
  - Register `en_q <= enable_in` every cycle.
  - The upstream `overflow` holds its value while enable is low, so the level alone is not an event.
  - An overflow event (`ovf_evt`) is `overflow_in && en_q`.
- **Epoch.**
  - `epoch <= epoch + 1` on each `ovf_evt`.
  - The epoch wraps modulo 2^EPOCH_WIDTH silently.
- **Capture value.**
  - The captured entry is `{epoch_eff, count_in}`, where `epoch_eff = epoch + ovf_evt`.
  - This keeps a capture on the cycle where `count_in` has just wrapped to 0 coherent with its epoch.
- **Push.**
  - A capture is accepted when `capture_in` is high and either `fill < DEPTH` or a pop occurs in the same cycle.
  - Otherwise it is dropped: `dropped <= 1` and `drop_cnt <= sat(drop_cnt + 1)`.
- **Pop.** A pop occurs when `m_valid && m_ready`.
- **FIFO order.**
  - First in, first out.
  - `m_count`/`m_epoch` are registered head values and are stable while `m_valid && !m_ready`.
- **Fill accounting.** `fill` is updated by +1 on push only, −1 on pop only, and unchanged on both or neither.
- **Clear.**
  - `clear_in` zeroes `epoch`, empties the FIFO, and clears `dropped`/`drop_cnt`.
  - Clear has priority over capture, pop and `ovf_evt` in the same cycle; all of them are discarded.
  - `en_q` still updates.
- **Reset.** All outputs are 0: `m_valid=0`, `m_count=0`, `m_epoch=0`, `fill=0`, `dropped=0`, `drop_cnt=0`. Internal `epoch=0` and `en_q=0`.
- **Reset mid-operation.** Asserting `rst_n` low immediately empties the FIFO and forces every output to its reset value; contents are lost.

## Timing

- **Capture to output.**
  - A capture accepted at edge t into an empty FIFO gives `m_valid=1` with its data after edge t.
  - There is no combinational path from `capture_in` to `m_*`.
- **`ovf_evt` latency.** The event is seen one cycle after the enabled upstream cycle that wrapped, which is the same cycle `overflow_in` first reads 1.
- **`fill`, `dropped`, `drop_cnt`.** All three update at the same edge as the push/pop/drop that causes them.
- **Throughput.** Sustained one capture per cycle with `m_ready` held high never drops.
- **`m_ready` while `m_valid=0`.** Ignored.

## Test plan

- Reset, then hold `m_ready=0`. Pulse `capture_in` at `count_in`=5, 9, 12 with no overflow. Expect `fill`=3. Then raise `m_ready`: expect entries (0,5), (0,9), (0,12) in order, and `fill` returning to 0.
- Drive `overflow_in=1` for 3 cycles with `enable_in` low the whole time (`en_q=0`). Expect the epoch unchanged. Then drive one cycle with `en_q=1`, `overflow_in=1`, `count_in=0` and `capture_in=1` in that same cycle. Expect the entry (1,0).
- With `DEPTH=4` and `m_ready=0`, issue 6 captures. Expect `fill`=4, `dropped`=1 and `drop_cnt`=2, and the first 4 values retained.
- With the FIFO full, assert `capture_in` and `m_ready` in the same cycle. Expect the capture accepted, the head popped, `fill` staying at 4, and `drop_cnt` unchanged.
- Assert `clear_in` together with `capture_in` while `fill`=2, epoch=7 and `dropped`=1. Expect the next cycle to show `fill`=0, `m_valid=0` and `dropped=0`; a subsequent capture yields epoch 0.
- Run 256 qualified overflow events with `EPOCH_WIDTH=8`, then capture. Expect `m_epoch`=0 (wrap). Then assert `rst_n=0` mid-stream: expect all outputs 0 immediately, before the next clock edge.
